instr_exec_unit: RTL and testbench



---
 rtl/instr_register_pkg.sv | 34 +++
 rtl/instr_divider.sv | 73 +++++++
 rtl/instr_exec_unit.sv | 199 +++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution unit:
// opcodes, operand/address/result types, execution FSM states and
// the divider step count.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } exec_state_t;

    localparam int DIV_STEPS = 32;

    // True for the opcodes that go through the iterative divider
    function automatic logic is_div_op(opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first step is taken on the start edge, so done rises after
// DIV_STEPS edges counting the start edge; quotient/remainder are valid
// while done is high. Operands are magnitudes; signs are handled by the
// caller.
module instr_divider
    import instr_register_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. Since rem < dvs the
    // shifted value is below 2*dvs, so W+1 bits cover the difference.
    function automatic logic [2*W-1:0] div_step(logic [W-1:0] rem,
                                                logic [W-1:0] quo,
                                                logic [W-1:0] dvs);
        logic [W:0] shifted;
        logic [W:0] diff;
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[W])
            return {diff[W-1:0], quo[W-2:0], 1'b1};
        else
            return {shifted[W-1:0], quo[W-2:0], 1'b0};
    endfunction

    // Step counter and partial quotient/remainder registers
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            {rem_q, quo_q} <= div_step('0, dividend, divisor);
            dvs_q          <= divisor;
            count_q        <= CNT_W'(1);
            busy_q         <= 1'b1;
        end else if (busy_q) begin
            if (count_q == CNT_W'(DIV_STEPS)) begin
                busy_q  <= 1'b0;
                count_q <= '0;
            end else begin
                {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
                count_q        <= count_q + 1'b1;
            end
        end
    end

    assign done      = busy_q && (count_q == CNT_W'(DIV_STEPS));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/instr_exec_unit.sv
// Execution unit behind the instruction register. Accepts one decoded
// instruction per handshake, executes simple ops in one cycle and
// DIV/MOD through the iterative divider, and holds a tagged result
// until the consumer takes it.
// Optional build macro INSTR_EXEC_STATS_EN adds saturating instruction
// and divide-by-zero counters as extra output ports.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int OP_W  = 32,
    parameter int RES_W = 64,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  opcode_t                 opcode,
    input  logic signed [OP_W-1:0]  operand_a,
    input  logic signed [OP_W-1:0]  operand_b,
    input  logic [TAG_W-1:0]        instr_tag,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] result,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    res_error
`ifdef INSTR_EXEC_STATS_EN
    ,
    output logic [15:0]             instr_count,
    output logic [15:0]             err_count
`endif
);

    exec_state_t       state_q;
    exec_state_t       state_d;
    logic              accept;
    logic              is_div;
    logic              div_by_zero;
    logic              div_start;
    logic              div_done;
    logic [OP_W-1:0]   div_quotient;
    logic [OP_W-1:0]   div_remainder;

    // Context of the division in flight, applied when the divider finishes
    logic [TAG_W-1:0]  pend_tag;
    logic              pend_mod;
    logic              pend_q_neg;
    logic              pend_r_neg;

    // Single-cycle ops, evaluated at result width so ADD/SUB/MULT never wrap
    function automatic logic signed [RES_W-1:0] simple_op(opcode_t op,
                                                          logic signed [OP_W-1:0] a,
                                                          logic signed [OP_W-1:0] b);
        logic signed [RES_W-1:0] ax;
        logic signed [RES_W-1:0] bx;
        ax = {{(RES_W-OP_W){a[OP_W-1]}}, a};
        bx = {{(RES_W-OP_W){b[OP_W-1]}}, b};
        case (op)
            PASSA:   return ax;
            PASSB:   return bx;
            ADD:     return ax + bx;
            SUB:     return ax - bx;
            MULT:    return ax * bx;
            default: return '0;
        endcase
    endfunction

    // Two's-complement magnitude; -2^(OP_W-1) maps to 2^(OP_W-1) unsigned
    function automatic logic [OP_W-1:0] magnitude(logic signed [OP_W-1:0] v);
        logic [OP_W-1:0] m;
        m = v;
        return v[OP_W-1] ? (~m + 1'b1) : m;
    endfunction

    // Restore signs: quotient negative when operand signs differ,
    // remainder takes the sign of the dividend
    function automatic logic signed [RES_W-1:0] div_fixup(logic is_mod,
                                                          logic q_neg,
                                                          logic r_neg,
                                                          logic [OP_W-1:0] q,
                                                          logic [OP_W-1:0] r);
        logic signed [RES_W-1:0] mag;
        logic                    neg;
        mag = is_mod ? {{(RES_W-OP_W){1'b0}}, r} : {{(RES_W-OP_W){1'b0}}, q};
        neg = is_mod ? r_neg : q_neg;
        return neg ? -mag : mag;
    endfunction

    assign is_div      = is_div_op(opcode);
    assign div_by_zero = (operand_b == '0);
    assign accept      = instr_valid && instr_ready;
    assign div_start   = accept && is_div && !div_by_zero;

    instr_divider #(
        .W (OP_W)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (magnitude(operand_a)),
        .divisor   (magnitude(operand_b)),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: an accept from IDLE or a consumed DONE picks the
    // op's path, so back-to-back instructions need no idle cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = div_start ? DIVIDE : DONE;
            end
            DIVIDE: begin
                if (div_done)
                    state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    if (accept)
                        state_d = div_start ? DIVIDE : DONE;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; res_ready feeds instr_ready combinationally
    always_comb begin
        instr_ready = (state_q == IDLE) || ((state_q == DONE) && res_ready);
        res_valid   = (state_q == DONE);
    end

    // Result register and pending-division context
    always_ff @(posedge clk) begin
        if (reset) begin
            result     <= '0;
            res_tag    <= '0;
            res_error  <= 1'b0;
            pend_tag   <= '0;
            pend_mod   <= 1'b0;
            pend_q_neg <= 1'b0;
            pend_r_neg <= 1'b0;
        end else if (accept) begin
            if (!is_div) begin
                result    <= simple_op(opcode, operand_a, operand_b);
                res_tag   <= instr_tag;
                res_error <= 1'b0;
            end else if (div_by_zero) begin
                result    <= '0;
                res_tag   <= instr_tag;
                res_error <= 1'b1;
            end else begin
                pend_tag   <= instr_tag;
                pend_mod   <= (opcode == MOD);
                pend_q_neg <= operand_a[OP_W-1] ^ operand_b[OP_W-1];
                pend_r_neg <= operand_a[OP_W-1];
            end
        end else if ((state_q == DIVIDE) && div_done) begin
            result    <= div_fixup(pend_mod, pend_q_neg, pend_r_neg,
                                   div_quotient, div_remainder);
            res_tag   <= pend_tag;
            res_error <= 1'b0;
        end
    end

`ifdef INSTR_EXEC_STATS_EN
    // Saturating increment so counters stick at full scale
    function automatic logic [15:0] sat_inc(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Accepted-instruction and divide-by-zero counters
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
            err_count   <= '0;
        end else begin
            if (accept)
                instr_count <= sat_inc(instr_count);
            if (accept && is_div && div_by_zero)
                err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: directed vector table,
// hand-written handshake/reset sequences and randomized instructions
// checked against an arithmetic reference model.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               instr_valid;
    logic               instr_ready;
    opcode_t            opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [4:0]         instr_tag;
    logic               res_valid;
    logic               res_ready;
    logic signed [63:0] result;
    logic [4:0]         res_tag;
    logic               res_error;
`ifdef INSTR_EXEC_STATS_EN
    logic [15:0]        instr_count;
    logic [15:0]        err_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_err    = 0;

    instr_exec_unit #(
        .OP_W  (32),
        .RES_W (64),
        .TAG_W (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .instr_tag   (instr_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .res_tag     (res_tag),
        .res_error   (res_error)
`ifdef INSTR_EXEC_STATS_EN
        ,
        .instr_count (instr_count),
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t            op;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic [4:0]         tag;
        logic signed [63:0] exp_res;
        bit                 exp_err;
        int                 exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit signed arithmetic, SV / and % semantics
    function automatic void model(input opcode_t op, input logic signed [31:0] a,
                                  input logic signed [31:0] b,
                                  output logic signed [63:0] r, output bit err,
                                  output int lat);
        longint la = a;
        longint lb = b;
        err = 1'b0;
        lat = 1;
        r   = 0;
        case (op)
            ZERO:  r = 0;
            PASSA: r = la;
            PASSB: r = lb;
            ADD:   r = la + lb;
            SUB:   r = la - lb;
            MULT:  r = la * lb;
            DIV, MOD: begin
                if (b == 0) begin
                    err = 1'b1;
                end else begin
                    r   = (op == DIV) ? la / lb : la % lb;
                    lat = 33;
                end
            end
            default: r = 0;
        endcase
    endfunction

    // Issue one instruction from idle, wait (bounded) for the result,
    // compare it, then consume it
    task automatic exec(input opcode_t op, input logic signed [31:0] a,
                        input logic signed [31:0] b, input logic [4:0] tag,
                        input logic signed [63:0] exp_res, input bit exp_err,
                        input int exp_lat, input string name);
        int edges;
        bit ready_leak;
        check({name, " ready"}, 64'(instr_ready), 64'd1);
        opcode      = op;
        operand_a   = a;
        operand_b   = b;
        instr_tag   = tag;
        instr_valid = 1'b1;
        res_ready   = 1'b0;
        tick();
        instr_valid = 1'b0;
        operand_a   = $urandom;
        operand_b   = $urandom;
        n_acc++;
        if (exp_err) n_err++;
        edges      = 1;
        ready_leak = 1'b0;
        while (!res_valid && edges < 40) begin
            if (instr_ready) ready_leak = 1'b1;
            tick();
            edges++;
        end
        check({name, " latency"}, 64'(edges), 64'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " tag"}, 64'(res_tag), 64'(tag));
        check({name, " error"}, 64'(res_error), 64'(exp_err));
        check({name, " busy_not_ready"}, 64'(ready_leak), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, " drained"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        logic signed [63:0] m_res;
        bit                 m_err;
        int                 m_lat;
        bit                 seen;
        logic signed [31:0] ra;
        logic signed [31:0] rb;

        vecs.push_back(vec_t'{ADD,   32'sh7FFFFFFF, 32'sd1,        5'd3,  64'sh0000_0000_8000_0000, 1'b0, 1});
        vecs.push_back(vec_t'{SUB,   32'sh80000000, 32'sd1,        5'd4,  64'shFFFF_FFFF_7FFF_FFFF, 1'b0, 1});
        vecs.push_back(vec_t'{MULT,  -32'sd5,       32'sd7,        5'd5,  -64'sd35,                 1'b0, 1});
        vecs.push_back(vec_t'{MULT,  32'sh80000000, 32'sh80000000, 5'd6,  64'sh4000_0000_0000_0000, 1'b0, 1});
        vecs.push_back(vec_t'{PASSA, -32'sd1,       32'sd99,       5'd7,  -64'sd1,                  1'b0, 1});
        vecs.push_back(vec_t'{PASSB, 32'sd12,       32'sd123,      5'd8,  64'sd123,                 1'b0, 1});
        vecs.push_back(vec_t'{ZERO,  32'sd55,       32'sd66,       5'd9,  64'sd0,                   1'b0, 1});
        vecs.push_back(vec_t'{DIV,   -32'sd7,       32'sd2,        5'd10, -64'sd3,                  1'b0, 33});
        vecs.push_back(vec_t'{MOD,   -32'sd7,       32'sd2,        5'd11, -64'sd1,                  1'b0, 33});
        vecs.push_back(vec_t'{DIV,   32'sd7,        -32'sd2,       5'd12, -64'sd3,                  1'b0, 33});
        vecs.push_back(vec_t'{MOD,   32'sd7,        -32'sd2,       5'd13, 64'sd1,                   1'b0, 33});
        vecs.push_back(vec_t'{DIV,   32'sh80000000, -32'sd1,       5'd14, 64'sd2147483648,          1'b0, 33});
        vecs.push_back(vec_t'{MOD,   32'sh80000000, -32'sd1,       5'd15, 64'sd0,                   1'b0, 33});
        vecs.push_back(vec_t'{DIV,   32'sd100,      32'sd3,        5'd16, 64'sd33,                  1'b0, 33});
        vecs.push_back(vec_t'{DIV,   32'sd9,        32'sd0,        5'd17, 64'sd0,                   1'b1, 1});
        vecs.push_back(vec_t'{MOD,   32'sd5,        32'sd0,        5'd18, 64'sd0,                   1'b1, 1});

        reset       = 1'b1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        opcode      = ZERO;
        operand_a   = '0;
        operand_b   = '0;
        instr_tag   = '0;

        // Reset held two cycles, then released
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset result", result, 64'd0);
        check("reset res_tag", 64'(res_tag), 64'd0);
        check("reset res_error", 64'(res_error), 64'd0);
        check("reset instr_ready", 64'(instr_ready), 64'd1);

        // Directed vector table
        foreach (vecs[i])
            exec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                 vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_lat,
                 $sformatf("vec%0d", i));

        // Result held under backpressure, then back-to-back accept
        check("b2b idle ready", 64'(instr_ready), 64'd1);
        opcode = MULT; operand_a = -32'sd5; operand_b = 32'sd7; instr_tag = 5'd4;
        instr_valid = 1'b1; res_ready = 1'b0;
        tick();
        instr_valid = 1'b0;
        n_acc++;
        check("hold valid", 64'(res_valid), 64'd1);
        check("hold result", result, -64'sd35);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("hold%0d result", k), result, -64'sd35);
            check($sformatf("hold%0d tag", k), 64'(res_tag), 64'd4);
            check($sformatf("hold%0d instr_ready", k), 64'(instr_ready), 64'd0);
            check($sformatf("hold%0d res_valid", k), 64'(res_valid), 64'd1);
        end
        opcode = SUB; operand_a = 32'sd10; operand_b = 32'sd3; instr_tag = 5'd9;
        instr_valid = 1'b1; res_ready = 1'b1;
        #1;
        check("b2b comb instr_ready", 64'(instr_ready), 64'd1);
        tick();
        instr_valid = 1'b0; res_ready = 1'b0;
        n_acc++;
        check("b2b valid", 64'(res_valid), 64'd1);
        check("b2b result", result, 64'sd7);
        check("b2b tag", 64'(res_tag), 64'd9);
        check("b2b error", 64'(res_error), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("b2b drained", 64'(res_valid), 64'd0);

        // Randomized instructions against the reference model
        for (int i = 0; i < 60; i++) begin
            opcode_t rop;
            rop = opcode_t'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: ra = 32'sh80000000;
                2: rb = -32'sd1;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            model(rop, ra, rb, m_res, m_err, m_lat);
            exec(rop, ra, rb, 5'($urandom), m_res, m_err, m_lat, $sformatf("rnd%0d", i));
        end

`ifdef INSTR_EXEC_STATS_EN
        check("stats instr_count", 64'(instr_count), 64'(n_acc));
        check("stats err_count", 64'(err_count), 64'(n_err));
`endif

        // Reset in the middle of a division aborts it
        opcode = DIV; operand_a = 32'sd100; operand_b = 32'sd3; instr_tag = 5'd21;
        instr_valid = 1'b1; res_ready = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("abort busy", 64'(instr_ready), 64'd0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort res_valid", 64'(res_valid), 64'd0);
        check("abort instr_ready", 64'(instr_ready), 64'd1);
        check("abort result", result, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("abort no result", 64'(seen), 64'd0);
        res_ready = 1'b0;
`ifdef INSTR_EXEC_STATS_EN
        check("abort instr_count", 64'(instr_count), 64'd0);
        check("abort err_count", 64'(err_count), 64'd0);
`endif

        // Unit still works after the aborted division
        exec(MOD, 32'sd100, 32'sd7, 5'd22, 64'sd2, 1'b0, 33, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
